// File: rtl/div_ctrl.sv
// Execute-stage DIV/DIVU controller: latches operands, sequences the iterative
// divider through start/annul, stalls EX until ready, then pulses the HI/LO write.
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_valid_i,
  input  logic        div_signed_i,
  input  logic [31:0] div_op1_i,
  input  logic [31:0] div_op2_i,
  input  logic        flush_i,
  output logic        stall_req_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        hi_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   abort_cnt;
  logic   hi_we_q;
  logic   latch_en;
  logic   capture_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      abort_cnt     <= 1'b0;
      hi_we_q       <= 1'b0;
      div_signed_o  <= 1'b0;
      div_opdata1_o <= '0;
      div_opdata2_o <= '0;
      hi_o          <= '0;
      lo_o          <= '0;
    end else begin
      state     <= state_nxt;
      hi_we_q   <= capture_en;
      // Counts the two quiet cycles spent in ABORT; zero everywhere else.
      abort_cnt <= (state == ABORT) ? ~abort_cnt : 1'b0;
      // Operands stay frozen until the next issue; the divider re-reads them
      // for its final sign correction.
      if (latch_en) begin
        div_signed_o  <= div_signed_i;
        div_opdata1_o <= div_op1_i;
        div_opdata2_o <= div_op2_i;
      end
      if (capture_en) begin
        hi_o <= div_result_i[63:32];
        lo_o <= div_result_i[31:0];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    latch_en    = 1'b0;
    capture_en  = 1'b0;
    div_start_o = 1'b0;
    stall_req_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (div_valid_i && !flush_i) begin
          latch_en    = 1'b1;
          stall_req_o = 1'b1;
          state_nxt   = BUSY;
        end
      end
      BUSY: begin
        stall_req_o = 1'b1;
        div_start_o = !flush_i;
        if (flush_i) begin
          state_nxt = ABORT;
        end else if (div_ready_i) begin
          capture_en = 1'b1;
          state_nxt  = DONE;
        end
      end
      // The instruction is still in EX here, so div_valid_i must not re-issue.
      DONE: state_nxt = IDLE;
      ABORT: begin
        if (abort_cnt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign div_annul_o = flush_i;
  assign hi_we_o     = hi_we_q & ~flush_i;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural iterative divider
// (36 start cycles to ready, 4 for a zero divisor).
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_valid_i, div_signed_i, flush_i;
  logic [31:0] div_op1_i, div_op2_i;
  logic        stall_req_o, div_start_o, div_annul_o, div_signed_o;
  logic [31:0] div_opdata1_o, div_opdata2_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        hi_we_o;
  logic [31:0] hi_o, lo_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .div_valid_i  (div_valid_i),
    .div_signed_i (div_signed_i),
    .div_op1_i    (div_op1_i),
    .div_op2_i    (div_op2_i),
    .flush_i      (flush_i),
    .stall_req_o  (stall_req_o),
    .div_start_o  (div_start_o),
    .div_annul_o  (div_annul_o),
    .div_signed_o (div_signed_o),
    .div_opdata1_o(div_opdata1_o),
    .div_opdata2_o(div_opdata2_o),
    .div_result_i (div_result_i),
    .div_ready_i  (div_ready_i),
    .hi_we_o      (hi_we_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  // Divider model: counts consecutive start cycles, answers from the latched operands.
  logic [5:0]  dcnt;
  logic [31:0] dq, dr;
  always @(posedge clk) begin
    if (rst || div_annul_o || !div_start_o) dcnt <= '0;
    else                                    dcnt <= dcnt + 6'd1;
  end
  always_comb begin
    dq = '0;
    dr = '0;
    if (div_opdata2_o != 32'd0) begin
      if (div_signed_o) begin
        dq = $signed(div_opdata1_o) / $signed(div_opdata2_o);
        dr = $signed(div_opdata1_o) % $signed(div_opdata2_o);
      end else begin
        dq = div_opdata1_o / div_opdata2_o;
        dr = div_opdata1_o % div_opdata2_o;
      end
    end
    div_result_i = {dr, dq};
    div_ready_i  = div_start_o && (dcnt == ((div_opdata2_o == 32'd0) ? 6'd3 : 6'd35));
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one divide at the current (IDLE) cycle and follows it to DONE+1.
  task automatic run_div(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int est, input bit fl_done);
    int n, starts, early_we;
    div_valid_i = 1'b1; div_signed_i = sg; div_op1_i = a; div_op2_i = b;
    #1;
    n = 0; starts = 0; early_we = 0;
    while (stall_req_o && n < 100) begin
      if (div_start_o) starts++;
      if (hi_we_o) early_we++;
      n++;
      if (n == 3) div_op1_i = ~a;
      step();
    end
    if (n >= 100) chk({tag, " timeout"}, 64'(n), 64'(est));
    chk({tag, " stall cycles"}, 64'(n), 64'(est));
    chk({tag, " start cycles"}, 64'(starts), 64'(est - 1));
    chk({tag, " we while stalled"}, 64'(early_we), 64'd0);
    chk({tag, " opdata1 frozen"}, 64'(div_opdata1_o), 64'(a));
    chk({tag, " start in done"}, 64'(div_start_o), 64'd0);
    if (fl_done) begin
      flush_i = 1'b1;
      #1;
      chk({tag, " we flushed"}, 64'(hi_we_o), 64'd0);
      chk({tag, " annul in done"}, 64'(div_annul_o), 64'd1);
    end else begin
      chk({tag, " we"}, 64'(hi_we_o), 64'd1);
      chk({tag, " hi"}, 64'(hi_o), 64'(eh));
      chk({tag, " lo"}, 64'(lo_o), 64'(el));
    end
    step();
    flush_i = 1'b0; div_valid_i = 1'b0;
    #1;
    chk({tag, " we after done"}, 64'(hi_we_o), 64'd0);
    chk({tag, " idle no stall"}, 64'(stall_req_o), 64'd0);
  endtask

  initial begin
    rst = 1'b1; div_valid_i = 1'b0; div_signed_i = 1'b0; flush_i = 1'b0;
    div_op1_i = '0; div_op2_i = '0;
    step(); step();
    chk("rst stall", 64'(stall_req_o), 64'd0);
    chk("rst start", 64'(div_start_o), 64'd0);
    chk("rst annul", 64'(div_annul_o), 64'd0);
    chk("rst we", 64'(hi_we_o), 64'd0);
    chk("rst regs", {div_opdata1_o, div_opdata2_o}, 64'd0);
    chk("rst hilo", {hi_o, lo_o}, 64'd0);
    rst = 1'b0;
    step();

    run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 37, 1'b0);
    run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 37, 1'b0);
    run_div("divu 5/0", 1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 5, 1'b0);

    // Flush while IDLE with a valid instruction: nothing latched, no stall.
    div_valid_i = 1'b1; div_op1_i = 32'h1234; div_op2_i = 32'd3; flush_i = 1'b1;
    #1;
    chk("idle flush stall", 64'(stall_req_o), 64'd0);
    chk("idle flush annul", 64'(div_annul_o), 64'd1);
    step();
    flush_i = 1'b0; div_valid_i = 1'b0;
    #1;
    chk("idle flush no start", 64'(div_start_o), 64'd0);
    chk("idle flush no latch", 64'(div_opdata1_o), 64'hFFFF_FFF9 & 64'h0 | 64'd5);

    // Flush at cycle 10 of a divide, then two ABORT cycles.
    div_valid_i = 1'b1; div_signed_i = 1'b0; div_op1_i = 32'd100; div_op2_i = 32'd7;
    for (int i = 0; i < 10; i++) step();
    flush_i = 1'b1;
    #1;
    chk("flush annul", 64'(div_annul_o), 64'd1);
    chk("flush start", 64'(div_start_o), 64'd0);
    chk("flush we", 64'(hi_we_o), 64'd0);
    step();
    flush_i = 1'b0; div_op1_i = 32'd9; div_op2_i = 32'd3;
    #1;
    chk("abort1 stall", 64'(stall_req_o), 64'd0);
    chk("abort1 start", 64'(div_start_o), 64'd0);
    chk("abort1 we", 64'(hi_we_o), 64'd0);
    step();
    chk("abort2 stall", 64'(stall_req_o), 64'd0);
    chk("abort2 we", 64'(hi_we_o), 64'd0);
    step();
    run_div("divu 9/3", 1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 37, 1'b0);

    run_div("divu 20/6", 1'b0, 32'd20, 32'd6, 32'd2, 32'd3, 37, 1'b0);
    run_div("divu ffffffff/10", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 37, 1'b0);
    run_div("divu flush done", 1'b0, 32'd50, 32'd0, 32'd0, 32'd0, 5, 1'b1);

    // Reset in the middle of BUSY.
    div_valid_i = 1'b1; div_op1_i = 32'd77; div_op2_i = 32'd5;
    for (int i = 0; i < 8; i++) step();
    rst = 1'b1; div_valid_i = 1'b0;
    step();
    chk("midrst stall", 64'(stall_req_o), 64'd0);
    chk("midrst start", 64'(div_start_o), 64'd0);
    chk("midrst we", 64'(hi_we_o), 64'd0);
    chk("midrst regs", {div_opdata1_o, div_opdata2_o}, 64'd0);
    chk("midrst hilo", {hi_o, lo_o}, 64'd0);
    rst = 1'b0;
    step();
    run_div("divu 77/5", 1'b0, 32'd77, 32'd5, 32'd2, 32'd15, 37, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Execute-stage control for DIV/DIVU in the 5-stage MIPS pipeline, sitting directly upstream of the iterative 32-bit divider. It latches operands, drives the divider's start/annul handshake, and stalls the pipeline until the divider reports ready. It then emits a one-cycle HI/LO write of {remainder, quotient} aligned with the instruction leaving EX. Flushes abort an in-flight divide without writing HI/LO.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock
- rst  in  1  reset; rst, synchronous, active-high; clock clk
- div_valid_i  in  1  DIV/DIVU present in EX; held until stall_req_o drops
- div_signed_i  in  1  1 = DIV, 0 = DIVU
- div_op1_i  in  32  dividend (rs)
- div_op2_i  in  32  divisor (rt)
- flush_i  in  1  pipeline flush/exception; kills current divide
- stall_req_o  out  1  stall request to pipeline control
- div_start_o  out  1  divider start
- div_annul_o  out  1  divider annul
- div_signed_o  out  1  registered signed flag
- div_opdata1_o  out  32  registered dividend
- div_opdata2_o  out  32  registered divisor
- div_result_i  in  64  divider result; [63:32] remainder, [31:0] quotient
- div_ready_i  in  1  divider result valid
- hi_we_o  out  1  HI/LO write enable, one-cycle pulse
- hi_o  out  32  remainder for HI
- lo_o  out  32  quotient for LO

## Operation
- States: IDLE, BUSY, DONE, ABORT (2-bit).
- IDLE: div_valid_i=1 and flush_i=0 -> latch div_signed_i/op1/op2 into the output registers; go to BUSY. div_start_o=0 in IDLE.
- div_opdata1_o/div_opdata2_o/div_signed_o stay frozen from latch until the next IDLE latch. The divider re-reads the operands for its final sign fix-up.
- BUSY: div_start_o=1 unless flush_i.
  - div_ready_i=1 -> hi_o<=div_result_i[63:32], lo_o<=div_result_i[31:0], hi_we_o<=1; go to DONE.
  - flush_i=1 (priority over ready) -> no capture; go to ABORT.
- DONE: div_start_o=0, stall_req_o=0. div_valid_i is ignored, because the same instruction is still in EX. Go to IDLE.
- ABORT: div_start_o=0 for exactly 2 cycles (1-bit counter), then IDLE. This guarantees the divider is back in its free state before any new start.
- Combinational outputs:
  - stall_req_o = (IDLE & div_valid_i & ~flush_i) | BUSY
  - div_annul_o = flush_i
  - hi_we_o = hi_we_q & ~flush_i
- hi_we_q is set only on BUSY->DONE and cleared in every other cycle.
- Divide-by-zero is issued normally; the divider returns 0, so HI=LO=0.
- No signed arithmetic in this block; sign handling belongs to the divider.

## Timing
- Reset: state=IDLE, all registered outputs 0. stall_req_o, div_start_o, div_annul_o and hi_we_o are 0 while rst=1 with flush_i=0.
- Reset mid-divide: returns to IDLE with no write. The divider shares rst.
- Issue at cycle 0 (IDLE, valid) with nonzero divisor:
  - div_start_o high cycles 1-36.
  - div_ready_i seen at cycle 36.
  - DONE at cycle 37: hi_we_o=1, stall_req_o=0.
  - stall_req_o high cycles 0-36.
- Divisor zero: div_ready_i at cycle 4, DONE at cycle 5.
- Back-to-back divides: the next DIV is latched no earlier than IDLE at cycle DONE+1.
- flush_i in IDLE with valid: no latch, no stall.
- flush_i in DONE: write suppressed; state still goes to IDLE.

## Test plan
- DIVU 100/7 -> stall 37 cycles (0-36); single hi_we_o pulse with hi_o=2, lo_o=14; div_start_o low in DONE.
- DIV -7/2 (0xFFFFFFF9, 2) -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFD. div_opdata1_o stays 0xFFFFFFF9 throughout, even while div_op1_i changes mid-operation.
- DIVU 5/0 -> hi_we_o at cycle 5 with hi_o=lo_o=0; stall high cycles 0-4.
- flush_i at cycle 10 of a divide -> div_annul_o=1 that cycle, no hi_we_o, 2 ABORT cycles. A divide issued next in IDLE completes correctly (e.g. 9/3 -> lo=3, hi=0).
- Two consecutive DIVU (20/6, then 0xFFFFFFFF/0x10) -> exactly two write pulses: (hi=2, lo=3), then (hi=0xF, lo=0x0FFFFFFF).
- rst asserted mid-BUSY -> next cycle all outputs 0 and state IDLE; a subsequent divide completes with correct values.
